// File: rtl/alu_serial_accel_if.sv
// alu_serial_accel_if: request/result handshake bundle for alu_serial_accel.
// The master drives requests and out_ready; the slave (the ALU) returns results.
interface alu_serial_accel_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] ia;
   logic [WIDTH-1:0] ib;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, op, ia, ib, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, op, ia, ib, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/alu_serial_accel.sv
// alu_serial_accel: digit-serial ADD/SUB/INC/DEC, DIGIT bits per cycle, LSB digit first.
// Define ALU_SAT_EN to clamp the result to the signed limit of x on overflow.
module alu_serial_accel #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   alu_serial_accel_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] x_sh, y_sh, work_q;
   logic             carry_q;
   logic [CW-1:0]    dcnt;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q, zero_q;

   logic [WIDTH-1:0] x_in, y_in;
   logic             cin_in;
   logic [DIGIT-1:0] xs, ys;
   logic [DIGIT:0]   dsum;
   logic             cin_msb, ovf_nx;
   logic [WIDTH-1:0] res_nx, sat_res;

   // NOTE: state registers use <= so every flop samples pre-edge values; = here would race.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nx = RUN;
         end
         RUN: if (dcnt == LAST) state_nx = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Every op is mapped onto x + y + cin at accept time.
   always_comb begin
      x_in   = bus.ia;
      y_in   = bus.ib;
      cin_in = 1'b0;
      case (bus.op)
         2'b00: ;
         2'b01: begin y_in = ~bus.ib; cin_in = 1'b1; end
         2'b10: begin x_in = bus.ib; y_in = '0; cin_in = 1'b1; end
         default: begin x_in = bus.ib; y_in = '1; end
      endcase
   end

   // One digit slice per cycle; the finished digit shifts in from the top of work_q.
   always_comb begin
      xs      = x_sh[DIGIT-1:0];
      ys      = y_sh[DIGIT-1:0];
      dsum    = {1'b0, xs} + {1'b0, ys} + (DIGIT+1)'(carry_q);
      cin_msb = dsum[DIGIT-1] ^ xs[DIGIT-1] ^ ys[DIGIT-1];
      ovf_nx  = cin_msb ^ dsum[DIGIT];
      res_nx  = (work_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
   end

`ifdef ALU_SAT_EN
   logic xmsb_q;

   always_ff @(posedge clk) begin
      if (rst)                                  xmsb_q <= 1'b0;
      else if (state == IDLE && bus.in_valid)   xmsb_q <= x_in[WIDTH-1];
   end

   always_comb begin
      sat_res = res_nx;
      if (ovf_nx) sat_res = xmsb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   assign sat_res = res_nx;
`endif

   // NOTE: operand and result registers are reset too, so an aborted operation leaves no trace.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_sh    <= '0;
         y_sh    <= '0;
         work_q  <= '0;
         carry_q <= 1'b0;
         dcnt    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               x_sh    <= x_in;
               y_sh    <= y_in;
               work_q  <= '0;
               carry_q <= cin_in;
               dcnt    <= '0;
            end
            RUN: begin
               x_sh    <= x_sh >> DIGIT;
               y_sh    <= y_sh >> DIGIT;
               work_q  <= res_nx;
               carry_q <= dsum[DIGIT];
               if (dcnt == LAST) begin
                  dcnt   <= '0;
                  sum_q  <= sat_res;
                  cout_q <= dsum[DIGIT];
                  ovf_q  <= ovf_nx;
                  zero_q <= (sat_res == '0);
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;
endmodule

// File: tb/tb_alu_serial_accel.sv
// tb_alu_serial_accel: directed vectors on three builds (8/4, 16/1, 16/16) sharing one stimulus set.
// Define ALU_SAT_EN for both bench and RTL to check the clamped results.
module tb_alu_serial_accel;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a, b, s_wrap, s_sat;
      logic        c, v, z;
   } vec_t;

   int          sel;
   logic        in_valid_s, out_ready_s;
   logic [1:0]  op_s;
   logic [15:0] ia_s, ib_s;
   logic        in_ready_m, out_valid_m, cout_m, ovf_m, zero_m;
   logic [15:0] sum_m;
   int          tests_run = 0;
   int          errors    = 0;
   vec_t        vec8 [9];
   vec_t        vec16[9];

   alu_serial_accel_if #(.WIDTH(8))  bus_a ();
   alu_serial_accel_if #(.WIDTH(16)) bus_b ();
   alu_serial_accel_if #(.WIDTH(16)) bus_c ();

   assign bus_a.in_valid  = in_valid_s  && (sel == 0);
   assign bus_a.out_ready = out_ready_s && (sel == 0);
   assign bus_a.op        = op_s;
   assign bus_a.ia        = ia_s[7:0];
   assign bus_a.ib        = ib_s[7:0];
   assign bus_b.in_valid  = in_valid_s  && (sel == 1);
   assign bus_b.out_ready = out_ready_s && (sel == 1);
   assign bus_b.op        = op_s;
   assign bus_b.ia        = ia_s;
   assign bus_b.ib        = ib_s;
   assign bus_c.in_valid  = in_valid_s  && (sel == 2);
   assign bus_c.out_ready = out_ready_s && (sel == 2);
   assign bus_c.op        = op_s;
   assign bus_c.ia        = ia_s;
   assign bus_c.ib        = ib_s;

   alu_serial_accel #(.WIDTH(8),  .DIGIT(4))  dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   alu_serial_accel #(.WIDTH(16), .DIGIT(1))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   alu_serial_accel #(.WIDTH(16), .DIGIT(16)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

   always_comb begin
      case (sel)
         0: begin
            in_ready_m = bus_a.in_ready; out_valid_m = bus_a.out_valid; sum_m = {8'h00, bus_a.sum};
            cout_m = bus_a.cout; ovf_m = bus_a.ovf; zero_m = bus_a.zero;
         end
         1: begin
            in_ready_m = bus_b.in_ready; out_valid_m = bus_b.out_valid; sum_m = bus_b.sum;
            cout_m = bus_b.cout; ovf_m = bus_b.ovf; zero_m = bus_b.zero;
         end
         default: begin
            in_ready_m = bus_c.in_ready; out_valid_m = bus_c.out_valid; sum_m = bus_c.sum;
            cout_m = bus_c.cout; ovf_m = bus_c.ovf; zero_m = bus_c.zero;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         errors++;
         $display("FAIL sel=%0d %s: got %h expected %h", sel, tag, got, exp);
      end
   endtask

   function automatic int ndig_of(input int s);
      case (s)
         0:       return 2;
         1:       return 16;
         default: return 1;
      endcase
   endfunction

   function automatic logic [15:0] exp_sum(input vec_t v);
`ifdef ALU_SAT_EN
      return v.s_sat;
`else
      return v.s_wrap;
`endif
   endfunction

   // Call and return at a negedge; inputs are scrambled after accept since they are don't-care.
   task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      while (!in_ready_m && n < 100) begin
         @(posedge clk); @(negedge clk); n++;
      end
      check("in_ready before accept", in_ready_m, 1);
      op_s = op; ia_s = a; ib_s = b; in_valid_s = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid_s = 1'b0; op_s = ~op; ia_s = ~a; ib_s = ~b;
   endtask

   task automatic finish_op(input vec_t v, input string tag, input bit handshake);
      int lat = 0;
      while (!out_valid_m && lat < 200) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      check({tag, " latency"}, lat, ndig_of(sel));
      check({tag, " sum"},  sum_m,  exp_sum(v));
      check({tag, " cout"}, cout_m, v.c);
      check({tag, " ovf"},  ovf_m,  v.v);
      check({tag, " zero"}, zero_m, v.z);
      check({tag, " in_ready in DONE"}, in_ready_m, 0);
      if (handshake) begin
         out_ready_s = 1'b1;
         @(posedge clk); @(negedge clk);
         out_ready_s = 1'b0;
         check({tag, " out_valid after handshake"}, out_valid_m, 0);
         check({tag, " in_ready after handshake"}, in_ready_m, 1);
         check({tag, " sum held in IDLE"}, sum_m, exp_sum(v));
      end
   endtask

   initial begin
      vec_t one_plus_one;
      vec_t stall_v;
      vec8[0]  = '{2'b00, 16'h00F0, 16'h0020, 16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0};
      vec8[1]  = '{2'b01, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
      vec8[2]  = '{2'b01, 16'h0003, 16'h0005, 16'h00FE, 16'h00FE, 1'b0, 1'b0, 1'b0};
      vec8[3]  = '{2'b10, 16'h0055, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
      vec8[4]  = '{2'b11, 16'h0033, 16'h0000, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0};
      vec8[5]  = '{2'b11, 16'h0000, 16'h0080, 16'h007F, 16'h0080, 1'b1, 1'b1, 1'b0};
      vec8[6]  = '{2'b00, 16'h007F, 16'h0001, 16'h0080, 16'h007F, 1'b0, 1'b1, 1'b0};
      vec8[7]  = '{2'b01, 16'h0080, 16'h0001, 16'h007F, 16'h0080, 1'b1, 1'b1, 1'b0};
      vec8[8]  = '{2'b00, 16'h00AB, 16'h0011, 16'h00BC, 16'h00BC, 1'b0, 1'b0, 1'b0};
      vec16[0] = '{2'b00, 16'hF000, 16'h2000, 16'h1000, 16'h1000, 1'b1, 1'b0, 1'b0};
      vec16[1] = '{2'b01, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
      vec16[2] = '{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vec16[3] = '{2'b10, 16'h5555, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
      vec16[4] = '{2'b11, 16'h3333, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      vec16[5] = '{2'b11, 16'h0000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0};
      vec16[6] = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      vec16[7] = '{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0};
      vec16[8] = '{2'b00, 16'h1234, 16'h4321, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0};
      one_plus_one = '{2'b00, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0};

      sel = 0; in_valid_s = 1'b0; out_ready_s = 1'b0; op_s = 2'b00; ia_s = '0; ib_s = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("reset in_ready",  in_ready_m,  1);
         check("reset out_valid", out_valid_m, 0);
         check("reset sum",       sum_m,       0);
         check("reset flags",     {cout_m, ovf_m, zero_m}, 0);
      end
      @(negedge clk);

      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         for (int i = 0; i < 9; i++) begin
            vec_t v;
            v = (s == 0) ? vec8[i] : vec16[i];
            start_op(v.op, v.a, v.b);
            finish_op(v, $sformatf("vec%0d", i), 1'b1);
         end

         // Consumer stalls in DONE while a new request waits; it is taken right after the handshake.
         stall_v = (s == 0) ? vec8[0] : vec16[0];
         start_op(stall_v.op, stall_v.a, stall_v.b);
         finish_op(stall_v, "stall", 1'b0);
         op_s = 2'b00; ia_s = 16'h0001; ib_s = 16'h0001; in_valid_s = 1'b1;
         repeat (5) begin
            @(posedge clk); @(negedge clk);
            check("stall in_ready",  in_ready_m,  0);
            check("stall out_valid", out_valid_m, 1);
            check("stall sum",       sum_m,       exp_sum(stall_v));
            check("stall flags",     {cout_m, ovf_m, zero_m}, {stall_v.c, stall_v.v, stall_v.z});
         end
         out_ready_s = 1'b1;
         @(posedge clk); @(negedge clk);
         out_ready_s = 1'b0;
         check("post-stall out_valid", out_valid_m, 0);
         check("post-stall in_ready",  in_ready_m,  1);
         @(posedge clk); @(negedge clk);
         in_valid_s = 1'b0; op_s = 2'b11; ia_s = '1; ib_s = '1;
         check("queued request accepted", in_ready_m, 0);
         finish_op(one_plus_one, "queued add", 1'b1);

         // Reset during the first RUN cycle discards the operation.
         start_op(2'b00, 16'h00FF, 16'h00FF);
         rst = 1'b1;
         @(posedge clk); @(negedge clk);
         rst = 1'b0;
         check("mid-run reset out_valid", out_valid_m, 0);
         check("mid-run reset in_ready",  in_ready_m,  1);
         check("mid-run reset sum",       sum_m,       0);
         check("mid-run reset flags",     {cout_m, ovf_m, zero_m}, 0);
         @(posedge clk); @(negedge clk);
         check("post-reset idle out_valid", out_valid_m, 0);
         start_op(2'b00, 16'h0001, 16'h0001);
         finish_op(one_plus_one, "post-reset add", 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
